// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store controller:
// access sizes, FSM states and byte/half lane selects.
package mem_access_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   localparam logic [1:0] LANE_B0 = 2'd0;
   localparam logic [1:0] LANE_B1 = 2'd1;
   localparam logic [1:0] LANE_B2 = 2'd2;
   localparam logic [1:0] LANE_B3 = 2'd3;

   localparam logic LANE_HLO = 1'b0;
   localparam logic LANE_HHI = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_MRG,
      S_WR,
      S_RESP
   } state_t;

   // Misaligned half/word or the reserved size code.
   function automatic logic req_bad(
      input logic [1:0] size,
      input logic [1:0] lane
   );
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_HALF: bad = lane[0];
         SZ_WORD: bad = (lane != 2'b00);
         SZ_ILL:  bad = 1'b1;
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response and word-memory port bundle
// between execute, the controller and the memory stage.
interface mem_access_ctrl_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;

   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;

   modport slave (
      input  req_valid, req_we, req_size,
      input  req_unsigned, req_addr, req_wdata,
      input  mem_dout,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_err,
      output mem_we, mem_addr, mem_din
   );

   modport master (
      output req_valid, req_we, req_size,
      output req_unsigned, req_addr, req_wdata,
      output mem_dout,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_err,
      input  mem_we, mem_addr, mem_din
   );

endinterface

// File: rtl/mem_lane_fmt.sv
// Byte/half lane handling: merge for sub-word
// stores, extract and extend for loads.
module mem_lane_fmt
   import mem_access_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        uns,
   output logic [31:0] merged,
   output logic [31:0] ld_data
);

   logic [7:0]  b;
   logic [15:0] h;

   // Replace the addressed lane(s) of the old word.
   always_comb begin
      merged = word;
      case (size)
         SZ_BYTE: begin
            case (lane)
               LANE_B0: merged[7:0]   = wdata[7:0];
               LANE_B1: merged[15:8]  = wdata[7:0];
               LANE_B2: merged[23:16] = wdata[7:0];
               LANE_B3: merged[31:24] = wdata[7:0];
               default: merged = word;
            endcase
         end
         SZ_HALF: begin
            if (lane[1] == LANE_HHI)
               merged[31:16] = wdata[15:0];
            else
               merged[15:0] = wdata[15:0];
         end
         SZ_WORD: merged = wdata;
         default: merged = word;
      endcase
   end

   // Pick the addressed lane and sign/zero extend it.
   always_comb begin
      b = 8'h00;
      case (lane)
         LANE_B0: b = word[7:0];
         LANE_B1: b = word[15:8];
         LANE_B2: b = word[23:16];
         LANE_B3: b = word[31:24];
         default: b = 8'h00;
      endcase
      h = (lane[1] == LANE_HLO) ? word[15:0] : word[31:16];
      ld_data = 32'h0;
      case (size)
         SZ_BYTE: ld_data = {{24{~uns & b[7]}}, b};
         SZ_HALF: ld_data = {{16{~uns & h[15]}}, h};
         SZ_WORD: ld_data = word;
         default: ld_data = 32'h0;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller: one request in flight,
// sub-word stores done as read-modify-write.
module mem_access_ctrl
   import mem_access_pkg::*;
(
   input logic          clk,
   input logic          rst,
   mem_access_ctrl_if.slave bus
);

   state_t      state;
   state_t      nxt;

   logic        we_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [1:0]  lane_q;
   logic [31:0] wdata_q;
   logic [9:0]  maddr_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        ready;
   logic        hs;
   logic        bad_in;
   logic        mwe;
   logic [31:0] mdin;
   logic [31:0] merged;
   logic [31:0] ld_data;

   assign hs     = bus.req_valid & (state == S_IDLE) & ~rst;
   assign bad_in = req_bad(bus.req_size, bus.req_addr[1:0]);

   mem_lane_fmt u_fmt (
      .word    (bus.mem_dout),
      .wdata   (wdata_q),
      .size    (size_q),
      .lane    (lane_q),
      .uns     (uns_q),
      .merged  (merged),
      .ld_data (ld_data)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= nxt;
   end

   // Next state and memory-port strobes; reset masks writes.
   always_comb begin
      nxt   = state;
      ready = 1'b0;
      mwe   = 1'b0;
      mdin  = 32'h0;
      unique case (state)
         S_IDLE: begin
            ready = 1'b1;
            if (hs) begin
               if (bad_in)
                  nxt = S_RESP;
               else if (bus.req_we && bus.req_size == SZ_WORD)
                  nxt = S_WR;
               else
                  nxt = S_RD;
            end
         end
         S_RD:  nxt = S_MRG;
         S_MRG: begin
            if (we_q) begin
               mwe  = 1'b1;
               mdin = merged;
            end
            nxt = S_RESP;
         end
         S_WR: begin
            mwe  = 1'b1;
            mdin = wdata_q;
            nxt  = S_RESP;
         end
         S_RESP: nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
      if (rst) begin
         ready = 1'b0;
         mwe   = 1'b0;
         mdin  = 32'h0;
      end
   end

   // Request capture, word address and response latches.
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q    <= 1'b0;
         size_q  <= SZ_BYTE;
         uns_q   <= 1'b0;
         lane_q  <= 2'b00;
         wdata_q <= 32'h0;
         maddr_q <= 10'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         if (hs) begin
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            lane_q  <= bus.req_addr[1:0];
            wdata_q <= bus.req_wdata;
            if (bad_in) begin
               rdata_q <= 32'h0;
               err_q   <= 1'b1;
            end else begin
               maddr_q <= bus.req_addr[11:2];
            end
         end
         if (state == S_MRG) begin
            rdata_q <= we_q ? 32'h0 : ld_data;
            err_q   <= 1'b0;
         end
         if (state == S_WR) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
         end
      end
   end

   assign bus.req_ready = ready;
   assign bus.rsp_valid = (state == S_RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign bus.mem_we    = mwe;
   assign bus.mem_addr  = maddr_q;
   assign bus.mem_din   = mdin;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store controller between the execute stage and the 1024×32 data memory stage. Accepts one byte-addressed load or store per handshake and drives the word-only memory port (we/addr/din/dout). Sub-word stores are done by read-modify-write. Load data returns with sign or zero extension to the writeback stage.

## Interface
- No parameters; memory fixed at 1024 words × 32 bits (12-bit byte address).
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; transfer on req_valid & req_ready at clk edge
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0
- req_addr  in  12  byte address, little-endian lanes
- req_wdata  in  32  store data, right-aligned (byte uses [7:0], half uses [15:0])
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal size
- mem_we  out  1  to memory stage write enable
- mem_addr  out  10  word address = captured addr[11:2]
- mem_din  out  32  write data
- mem_dout  in  32  memory stage read data; valid the cycle after a we=0 cycle, held while we=1

## Operation
- States: IDLE, RD, MRG, WR, RESP.
- IDLE: req_ready=1. On handshake, capture we/size/unsigned/addr/wdata, then:
  - misaligned (half with addr[0]=1, word with addr[1:0]≠0) or size=11 → RESP with err=1, no memory access.
  - word store → WR.
  - load or byte/half store → RD.
- RD: mem_we=0, mem_addr driven → MRG.
- MRG: mem_dout now holds the addressed word.
  - load: extract lane (byte at addr[1:0], half at addr[1]), extend, latch rsp_rdata → RESP.
  - sub-word store: mem_we=1, mem_din = mem_dout with the target lane(s) replaced by wdata → RESP.
- WR: mem_we=1, mem_din=wdata → RESP.
- RESP: rsp_valid=1 for one cycle with rsp_err/rsp_rdata → IDLE.
- req_ready=0 in every state except IDLE. Only one request in flight.
- mem_addr holds its last value when not accessing. mem_din=0 when mem_we=0.

## Timing
- Handshake edge = cycle 0 reference; rsp_valid in:
  - error: cycle 1.
  - word store: write in cycle 1, rsp cycle 2.
  - load: read cycle 1, data cycle 2, rsp cycle 3.
  - sub-word store: read cycle 1, merged write cycle 2, rsp cycle 3.
- Next request accepted no earlier than the cycle after RESP.
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, mem_addr 0, mem_din 0.
- mem_we and req_ready are forced 0 in any cycle where rst=1, so a reset in MRG or WR suppresses the write at that edge.
- Reset mid-operation drops the request with no response. req_ready=1 the first cycle after rst deasserts.
- rsp_rdata/rsp_err hold until the next RESP.

## Structure
- Package mem_access_pkg holds:
  - size encodings: SZ_BYTE, SZ_HALF, SZ_WORD
  - state enum
  - lane-select constants
- Sub-module mem_lane_fmt (combinational):
  - store side: takes old word, wdata, size, addr[1:0]; produces the merged word.
  - load side: takes word, size, addr[1:0], unsigned; produces the extended load value.
  - Instantiated once; the FSM stays in mem_access_ctrl.

## Test plan
- Word store addr 0x004, data 0xDEADBEEF → mem_we=1, mem_addr=1, mem_din=0xDEADBEEF in cycle 1; rsp_valid cycle 2, err 0. A following word load from 0x004 returns 0xDEADBEEF.
- RAM[1]=0x8899AABB. Signed byte load from 0x007 → rsp_rdata 0xFFFFFF88 in cycle 3. Unsigned → 0x00000088. Signed half load from 0x004 → 0xFFFFAABB.
- RAM[1]=0x8899AABB. Half store 0x1234 to 0x006 → cycle 1 we=0, cycle 2 we=1 with din 0x1234AABB. Byte store 0x55 to 0x005 then gives 0x123455BB.
- Misaligned cases, each → rsp_valid in cycle 1, err 1, rdata 0, mem_we never asserted:
  - word load at 0x002
  - half store at 0x003
  - size=11
- rst pulsed during MRG of a byte store → mem_we=0 at that edge, RAM word unchanged, no rsp_valid, req_ready=1 the cycle after rst drops.
- req_valid held high with two loads back-to-back → req_ready low from cycle 1 through RESP. The second request is accepted at the first IDLE cycle and its rsp_valid comes 3 cycles later.
